// File: rtl/flag_branch_unit_pkg.sv
// Shared types and constants for the flag register and branch resolver.
// Opcodes, conditions, FSM states and flag bit positions.
package flag_branch_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_XOR    = 3'd2,
        OP_RED    = 3'd3,
        OP_SLL    = 3'd4,
        OP_SRA    = 3'd5,
        OP_ROR    = 3'd6,
        OP_PADDSB = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_NE     = 3'd0,
        COND_EQ     = 3'd1,
        COND_GT     = 3'd2,
        COND_LT     = 3'd3,
        COND_GTE    = 3'd4,
        COND_LTE    = 3'd5,
        COND_OVFL   = 3'd6,
        COND_UNCOND = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Which flag bits an opcode is allowed to overwrite.
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch condition check against a {Z,V,N} flag vector.
module cond_eval
    import flag_branch_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = !z;
            COND_EQ:     taken = z;
            COND_GT:     taken = !z && !n;
            COND_LT:     taken = n;
            COND_GTE:    taken = z || (!z && !n);
            COND_LTE:    taken = n || z;
            COND_OVFL:   taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register plus a small FSM that resolves
// flag-dependent branches, waiting out in-flight flag writers.
module flag_branch_unit
    import flag_branch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [2:0] ex_op,
    input  logic [2:0] ex_flags,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_req,
    input  logic [2:0] br_cond,
    output logic [2:0] flags_q,
    output logic       br_hazard,
    output logic       br_done,
    output logic       br_taken
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] cond_q;
    logic [2:0] eval_cond;
    logic [2:0] wr_mask;
    logic       commit;
    logic       latch_cond;
    logic       eval_taken;

    assign wr_mask   = flag_mask(ex_op);
    assign br_hazard = ex_valid && (wr_mask != 3'b000);
    assign commit    = ex_valid && !stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else if (commit) begin
            flags_q <= (flags_q & ~wr_mask) | (ex_flags & wr_mask);
        end
    end

    // In IDLE the live request is evaluated; in WAIT the latched one.
    assign eval_cond = (state_q == ST_IDLE) ? br_cond : cond_q;

    cond_eval u_cond_eval (
        .cond  (eval_cond),
        .flags (flags_q),
        .taken (eval_taken)
    );

    always_comb begin
        state_d    = state_q;
        latch_cond = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_req) begin
                    latch_cond = 1'b1;
                    state_d    = br_hazard ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (!br_hazard && !stall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d    = ST_IDLE;
            latch_cond = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cond_q   <= 3'b000;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            state_q  <= state_d;
            br_done  <= (state_d == ST_DONE);
            br_taken <= (state_d == ST_DONE) && eval_taken;
            if (latch_cond) begin
                cond_q <= br_cond;
            end
        end
    end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The port list SHALL be: clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 ex_valid  input  1  an ALU instruction occupies EX this cycle.
REQ-004 ex_op  input  3  ALU opcode in EX: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB.
REQ-005 ex_flags  input  3  ALU Flags output, bit2 Z, bit1 V, bit0 N.
REQ-006 stall  input  1  pipeline stall; EX does not advance this cycle.
REQ-007 flush  input  1  squash EX and abort any pending branch.
REQ-008 br_req  input  1  branch in ID requests resolution; sampled only in IDLE.
REQ-009 br_cond  input  3  condition: 0 NE, 1 EQ, 2 GT, 3 LT, 4 GTE, 5 LTE, 6 OVFL, 7 UNCOND.
REQ-010 flags_q  output  3  architectural flag register {Z,V,N}.
REQ-011 br_hazard  output  1  a flag writer in EX blocks resolution (combinational).
REQ-012 br_done  output  1  registered one-cycle pulse: resolution complete.
REQ-013 br_taken  output  1  registered; valid only while br_done=1, else 0.

Function
REQ-014 Flag commit SHALL occur at a rising edge only when ex_valid=1, stall=0, flush=0.
REQ-015 ADD and SUB SHALL write Z, V, N; XOR, SLL, SRA, ROR SHALL write Z only; RED and PADDSB SHALL write no flag; unwritten bits SHALL hold their value.
REQ-016 br_hazard SHALL equal ex_valid AND ex_op in {ADD, SUB, XOR, SLL, SRA, ROR}.
REQ-017 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-018 IDLE: br_req=1 and br_hazard=0 -> latch br_cond, evaluate against flags_q, go to DONE; br_req=1 and br_hazard=1 -> latch br_cond, go to WAIT; br_req=0 -> stay.
REQ-019 WAIT: br_hazard=1 or stall=1 -> stay; otherwise evaluate the latched condition against flags_q and go to DONE.
REQ-020 DONE: br_done=1, br_taken=registered result; next state IDLE unconditionally; br_req is ignored in DONE, and the requester SHALL drop br_req in the DONE cycle.
REQ-021 Latency SHALL be 1 cycle from br_req to br_done with no hazard, and at least 2 cycles with a hazard.
REQ-022 Conditions SHALL be: NE Z=0; EQ Z=1; GT Z=0 and N=0; LT N=1; GTE Z=1 or (Z=0 and N=0); LTE N=1 or Z=1; OVFL V=1; UNCOND always taken.
REQ-023 flush=1 SHALL force the next state to IDLE from any state, suppress the br_done pulse, and block that cycle's flag commit; flush has priority over br_req.
REQ-024 A flag commit and a branch evaluation at the same edge SHALL evaluate against the pre-commit flags_q; this case occurs only when hazard is 0, so no committed bit is read.

Reset
REQ-025 rst=1 SHALL asynchronously force flags_q=3'b000, state=IDLE, br_done=0, br_taken=0, and latched cond=0.
REQ-026 Reset asserted mid-WAIT or mid-DONE SHALL abandon the branch with no br_done pulse after release.

Structure
REQ-027 A shared package SHALL hold the ALU opcode enum, the branch condition enum, the FSM state enum, and the flag bit-index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0.
REQ-028 Condition evaluation SHALL be a purely combinational sub-module, cond_eval, with inputs cond[2:0] and flags[2:0] and output taken.

Verification
REQ-029 The bench SHALL cover: reset, then ex_valid=1, ex_op=SUB, ex_flags=3'b100 -> flags_q=3'b100 next cycle; then br_req with EQ and no hazard -> br_done=1 and br_taken=1 one cycle later.
REQ-030 flags_q=3'b101, ex_op=XOR, ex_flags=3'b000 -> flags_q=3'b001 (V and N held); ex_op=RED, ex_flags=3'b111 -> flags_q unchanged.
REQ-031 br_req with LT while ex_op=ADD, ex_flags=3'b001 in EX -> br_hazard=1, state WAIT, br_done two cycles after br_req, br_taken=1.
REQ-032 Hazard case with stall=1 held for 3 cycles -> stays in WAIT, flags_q unchanged, br_done one cycle after stall drops.
REQ-033 flush=1 in WAIT -> no br_done; flags_q unchanged, including the squashed writer.
REQ-034 All 8 conditions against all 8 flag values, compared to a reference model; rst pulse in DONE -> br_done=0 immediately.
